cpu8_core: RTL and testbench
============================

// Module: cpu8_core
// PURPOSE
//  Multi-cycle 8-bit core: the consumer of the instruction ROM. Drives `address`, samples `instruction`,
//  executes on four 8-bit registers s0..s3. Talks to a data memory with synchronous read.
//  Sits between the instruction ROM / tester and the data memory in the cpu8 top level.
// PARAMETERS
//  IMEM_DEPTH  32     valid instruction addresses are 0..IMEM_DEPTH-1; any other pc is a fault
//  RESET_PC    8'h00  pc value after clear
// PORTS
//  clk          in   1  single clock, rising edge
//  clear        in   1  reset: asynchronous, active-high
//  address      out  8  instruction address; always equals pc
//  instruction  in   8  combinational ROM data for `address`
//  dmem_addr    out  8  data memory address
//  dmem_wdata   out  8  store data
//  dmem_we      out  1  one-cycle write strobe
//  dmem_rdata   in   8  read data, valid the cycle after dmem_addr is presented
//  halted       out  1  high once HALT has executed or a fault has occurred
//  fault        out  1  high once pc went out of range at fetch
// BEHAVIOUR
//  ISA: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm2; imm2 is sign-extended (-2..+1).
//   00 ADD  s[rd] <= s[rs]+s[rt], mod 256, no carry kept
//   01 LW   s[rt] <= dmem[s[rs]+sext(imm2)]
//   10 SW   dmem[s[rs]+sext(imm2)] <= s[rt]
//   11 JMP  pc <= pc+1+sext(instr[5:0]); the value 8'hC3 is HALT, not a jump
//  All address arithmetic is 8-bit and wraps (255+1=0, 0-1=255).
//  State machine: FETCH -> EXEC -> (MEM, LW only) -> FETCH; HALT is terminal.
//   FETCH: if pc>=IMEM_DEPTH, set fault=1 and halted=1 and go to HALT.
//          Otherwise latch instruction into ir and go to EXEC.
//   EXEC:  ADD writes rd; pc+1.
//          SW drives dmem_we=1 for exactly this cycle; pc+1.
//          LW presents dmem_addr, then goes to MEM.
//          JMP loads the jump target.
//          HALT sets halted=1 and goes to HALT; pc is unchanged.
//   MEM:   s[rt] <= dmem_rdata; pc+1.
//   Cycle counts: ADD/SW/JMP take 2 cycles, LW takes 3.
//   HALT: no register or memory writes; leave it only through clear.
//  Outputs outside their active state: dmem_addr holds its last value; dmem_we=0.
//  Reset (clear=1, at any time, including mid-LW): state=FETCH, pc=RESET_PC, s0..s3=0, ir=0,
//   dmem_addr=0, dmem_wdata=0, dmem_we=0, halted=0, fault=0.
//   A store whose cycle is cut by clear is not issued.
//  ADD with rd equal to rs or rt: read the old values, then write.
//  JMP to self (offset -1) loops forever; this is legal.
// CONFIGURATION
//  CPU8_WB_TRACE_EN defined: adds ports wb_valid (out, 1), wb_reg (out, 2), wb_data (out, 8).
//   wb_valid pulses for one cycle, in the same cycle as each register write (ADD in EXEC, LW in MEM).
//   All three ports reset to 0.
//  Not defined: these ports and their logic do not exist. Core behaviour is identical either way.
// STRUCTURE
//  Package cpu8_pkg holds:
//   opcode localparams OP_ADD/OP_LW/OP_SW/OP_JMP
//   INSTR_HALT = 8'hC3
//   state enum {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT}
//   field-extract functions and sext2/sext6
//  Sub-module cpu8_regfile: 4x8 registers, 2 combinational read ports, 1 write port, async clear to 0.
// TESTING
//  1 Program {8'h49 LW s2,1(s0); 8'h27 ADD s3=s2+s1; 8'hC3}, dmem[1]=1 -> s2=1, s3=1.
//    halted rises exactly 7 cycles after clear falls; pc holds at 2.
//  2 Fibonacci chain 8'h49,27,39,18,07,32,2D,18 then 8'hC3 -> s0=21, s1=13, s2=8, s3=5.
//    No dmem_we pulse during the run.
//  3 s0=8'hFF, then SW s1,1(s0) with s1=8'h5A -> dmem_addr=8'h00, dmem_wdata=8'h5A;
//    dmem_we high for exactly 1 cycle.
//  4 JMP with offset +30 from pc=1 -> pc=32 -> fault=1 and halted=1 at the next FETCH; no writes.
//  5 clear asserted in the MEM cycle of an LW -> s[rt] stays 0; pc=0; FETCH resumes after release.
//  6 CPU8_WB_TRACE_EN build, test 1 program -> wb pulses (reg 2, data 1) then (reg 3, data 1), one cycle each.

Source files
------------

// File: rtl/cpu8_pkg.sv
// cpu8 shared definitions: opcodes, HALT encoding, FSM states, field helpers.
package cpu8_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [7:0] INSTR_HALT = 8'hC3;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  function automatic logic [1:0] op_f(input logic [7:0] i);
    return i[7:6];
  endfunction

  function automatic logic [1:0] rs_f(input logic [7:0] i);
    return i[5:4];
  endfunction

  function automatic logic [1:0] rt_f(input logic [7:0] i);
    return i[3:2];
  endfunction

  function automatic logic [1:0] rd_f(input logic [7:0] i);
    return i[1:0];
  endfunction

  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/cpu8_if.sv
// cpu8 core bus: instruction ROM, data memory and status.
// CPU8_WB_TRACE_EN adds the register write-back trace signals.
interface cpu8_if;
  logic [7:0] address;
  logic [7:0] instruction;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic       dmem_we;
  logic [7:0] dmem_rdata;
  logic       halted;
  logic       fault;
`ifdef CPU8_WB_TRACE_EN
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic [7:0] wb_data;

  modport master (
    output address, dmem_addr, dmem_wdata, dmem_we, halted, fault,
           wb_valid, wb_reg, wb_data,
    input  instruction, dmem_rdata
  );
  modport slave (
    input  address, dmem_addr, dmem_wdata, dmem_we, halted, fault,
           wb_valid, wb_reg, wb_data,
    output instruction, dmem_rdata
  );
`else
  modport master (
    output address, dmem_addr, dmem_wdata, dmem_we, halted, fault,
    input  instruction, dmem_rdata
  );
  modport slave (
    input  address, dmem_addr, dmem_wdata, dmem_we, halted, fault,
    output instruction, dmem_rdata
  );
`endif
endinterface

// File: rtl/cpu8_regfile.sv
// cpu8 register file: s0..s3, two combinational reads, one write, async clear.
module cpu8_regfile (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] ra_addr,
  input  logic [1:0] rb_addr,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] regs [4];

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/cpu8_core.sv
// cpu8 multi-cycle core: FETCH -> EXEC -> (MEM for LW) -> FETCH, HALT terminal.
// Optional write-back trace ports under CPU8_WB_TRACE_EN.
module cpu8_core
  import cpu8_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [7:0]  RESET_PC   = 8'h00
) (
  input logic    clk,
  input logic    clear,
  cpu8_if.master bus
);

  localparam logic [8:0] DEPTH9 = 9'(IMEM_DEPTH);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] dmem_addr_q;
  logic [7:0] dmem_wdata_q;
  logic       halted;
  logic       fault;

  logic [7:0] ra_data, rb_data;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] maddr;
  logic       exec_ld;
  logic       exec_st;

  cpu8_regfile u_rf (
    .clk     (clk),
    .clear   (clear),
    .ra_addr (rs_f(ir)),
    .rb_addr (rt_f(ir)),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // Decode of the EXEC cycle and register write-port steering.
  always_comb begin
    maddr    = ra_data + sext2(rd_f(ir));
    exec_ld  = (state == ST_EXEC) && (op_f(ir) == OP_LW);
    exec_st  = (state == ST_EXEC) && (op_f(ir) == OP_SW);
    rf_we    = 1'b0;
    rf_waddr = rd_f(ir);
    rf_wdata = ra_data + rb_data;
    if (state == ST_EXEC && op_f(ir) == OP_ADD) begin
      rf_we = 1'b1;
    end else if (state == ST_MEM) begin
      rf_we    = 1'b1;
      rf_waddr = rt_f(ir);
      rf_wdata = bus.dmem_rdata;
    end
  end

  // Main FSM with registered pc, ir, status and held memory bus values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if ({1'b0, pc} >= DEPTH9) begin
            fault  <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            ir    <= bus.instruction;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ir == INSTR_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            case (op_f(ir))
              OP_ADD: begin
                pc    <= pc + 8'd1;
                state <= ST_FETCH;
              end
              OP_LW: begin
                dmem_addr_q <= maddr;
                state       <= ST_MEM;
              end
              OP_SW: begin
                dmem_addr_q  <= maddr;
                dmem_wdata_q <= rb_data;
                pc           <= pc + 8'd1;
                state        <= ST_FETCH;
              end
              default: begin
                pc    <= pc + 8'd1 + sext6(ir[5:0]);
                state <= ST_FETCH;
              end
            endcase
          end
        end
        ST_MEM: begin
          pc    <= pc + 8'd1;
          state <= ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // The data address must be on the bus during EXEC itself so the synchronous
  // read returns in MEM; the registered copies only hold the value afterwards.
  always_comb begin
    bus.address    = pc;
    bus.halted     = halted;
    bus.fault      = fault;
    bus.dmem_we    = exec_st;
    bus.dmem_addr  = (exec_ld || exec_st) ? maddr : dmem_addr_q;
    bus.dmem_wdata = exec_st ? rb_data : dmem_wdata_q;
  end

`ifdef CPU8_WB_TRACE_EN
  // Write-back trace mirrors the register write port in the same cycle.
  always_comb begin
    bus.wb_valid = rf_we;
    bus.wb_reg   = rf_we ? rf_waddr : 2'b00;
    bus.wb_data  = rf_we ? rf_wdata : 8'h00;
  end
`else
`endif

endmodule

// File: tb/tb_cpu8_core.sv
// Self-checking bench for cpu8_core: directed programs plus random programs
// checked against an instruction-level interpreter.
module tb_cpu8_core;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic mem_load = 1'b0;

  cpu8_if bus ();

  cpu8_core #(.IMEM_DEPTH(32), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom      [256];
  logic [7:0] init_mem [256];
  logic [7:0] dmem     [256];

  assign bus.instruction = rom[bus.address];

  // Data memory with synchronous read; reloaded from init_mem on request.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_mem[i];
    end else if (bus.dmem_we) begin
      dmem[bus.dmem_addr] <= bus.dmem_wdata;
    end
    bus.dmem_rdata <= dmem[bus.dmem_addr];
  end

  // Observed stores and write-backs, one entry per active cycle.
  logic [15:0] st_q [$];
  logic [9:0]  wb_q [$];
  always @(negedge clk) begin
    if (!clear && bus.dmem_we) st_q.push_back({bus.dmem_addr, bus.dmem_wdata});
`ifdef CPU8_WB_TRACE_EN
    if (!clear && bus.wb_valid) wb_q.push_back({bus.wb_reg, bus.wb_data});
`endif
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference model.
  logic [7:0]  m_s [4];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_pc;
  logic        m_fault;
  int unsigned m_cycles;
  logic [15:0] m_st [$];
  logic [9:0]  m_wb [$];

  task automatic model_run();
    logic [7:0] pc, ins, a, imm;
    logic [1:0] rs, rt, rd;
    pc = 8'h00;
    for (int i = 0; i < 4; i++) m_s[i] = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = init_mem[i];
    m_fault = 1'b0;
    m_cycles = 0;
    m_st.delete();
    m_wb.delete();
    for (int step = 0; step < 1000; step++) begin
      if (pc >= 8'd32) begin
        m_fault = 1'b1;
        m_cycles += 1;
        break;
      end
      ins = rom[pc];
      if (ins == 8'hC3) begin
        m_cycles += 2;
        break;
      end
      rs  = ins[5:4];
      rt  = ins[3:2];
      rd  = ins[1:0];
      imm = {{6{ins[1]}}, ins[1:0]};
      a   = m_s[rs] + imm;
      case (ins[7:6])
        2'b00: begin
          m_s[rd] = m_s[rs] + m_s[rt];
          m_wb.push_back({rd, m_s[rd]});
          m_cycles += 2;
          pc = pc + 8'd1;
        end
        2'b01: begin
          m_s[rt] = m_mem[a];
          m_wb.push_back({rt, m_s[rt]});
          m_cycles += 3;
          pc = pc + 8'd1;
        end
        2'b10: begin
          m_mem[a] = m_s[rt];
          m_st.push_back({a, m_s[rt]});
          m_cycles += 2;
          pc = pc + 8'd1;
        end
        default: begin
          pc = pc + 8'd1 + {{2{ins[5]}}, ins[5:0]};
          m_cycles += 2;
        end
      endcase
    end
    m_pc = pc;
  endtask

  int unsigned st_base, wb_base;

  // Apply clear, reload memory, check reset values, release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    clear = 1'b1;
    mem_load = 1'b1;
    #1;
    chk({tag, ".rst_addr"}, 16'(bus.address), 16'h00);
    chk({tag, ".rst_halted"}, 16'(bus.halted), 16'h0);
    chk({tag, ".rst_fault"}, 16'(bus.fault), 16'h0);
    chk({tag, ".rst_we"}, 16'(bus.dmem_we), 16'h0);
    chk({tag, ".rst_daddr"}, 16'(bus.dmem_addr), 16'h00);
    chk({tag, ".rst_wdata"}, 16'(bus.dmem_wdata), 16'h00);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.rst_s%0d", tag, i), 16'(dut.u_rf.regs[i]), 16'h00);
    @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    st_base = st_q.size();
    wb_base = wb_q.size();
    clear = 1'b0;
  endtask

  task automatic wait_halt(output int unsigned n);
    n = 0;
    while (!bus.halted && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic compare_model(input string tag, input int unsigned n);
    chk({tag, ".cycles"}, 16'(n), 16'(m_cycles));
    chk({tag, ".pc"}, 16'(bus.address), 16'(m_pc));
    chk({tag, ".halted"}, 16'(bus.halted), 16'h1);
    chk({tag, ".fault"}, 16'(bus.fault), 16'(m_fault));
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.s%0d", tag, i), 16'(dut.u_rf.regs[i]), 16'(m_s[i]));
    chk({tag, ".nstores"}, 16'(st_q.size() - st_base), 16'(m_st.size()));
    for (int i = 0; i < m_st.size() && st_base + i < st_q.size(); i++)
      chk($sformatf("%s.store%0d", tag, i), st_q[st_base + i], m_st[i]);
`ifdef CPU8_WB_TRACE_EN
    chk({tag, ".nwb"}, 16'(wb_q.size() - wb_base), 16'(m_wb.size()));
    for (int i = 0; i < m_wb.size() && wb_base + i < wb_q.size(); i++)
      chk($sformatf("%s.wb%0d", tag, i), 16'(wb_q[wb_base + i]), 16'(m_wb[i]));
`endif
  endtask

  task automatic load_prog(input logic [7:0] p [$]);
    for (int i = 0; i < 256; i++) rom[i] = 8'hC3;
    for (int i = 0; i < p.size(); i++) rom[i] = p[i];
    for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
  endtask

  task automatic run_prog(input string tag);
    int unsigned n;
    model_run();
    do_reset(tag);
    wait_halt(n);
    compare_model(tag, n);
  endtask

  initial begin
    logic [7:0] p [$];
    logic [7:0] ins;
    int unsigned n;

    // Test 1: LW then ADD then HALT.
    p = '{8'h49, 8'h27, 8'hC3};
    load_prog(p);
    init_mem[1] = 8'h01;
    run_prog("t1");
    chk("t1.s2_direct", 16'(dut.u_rf.regs[2]), 16'h01);
    chk("t1.s3_direct", 16'(dut.u_rf.regs[3]), 16'h01);
    chk("t1.pc_direct", 16'(bus.address), 16'h02);
`ifdef CPU8_WB_TRACE_EN
    chk("t1.wb_count", 16'(wb_q.size() - wb_base), 16'd2);
    if (wb_q.size() - wb_base == 2) begin
      chk("t1.wb0", 16'(wb_q[wb_base]), {6'b0, 2'd2, 8'h01});
      chk("t1.wb1", 16'(wb_q[wb_base + 1]), {6'b0, 2'd3, 8'h01});
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("t1.pc_holds", 16'(bus.address), 16'h02);

    // Test 2: Fibonacci chain.
    p = '{8'h49, 8'h27, 8'h39, 8'h18, 8'h07, 8'h32, 8'h2D, 8'h18, 8'hC3};
    load_prog(p);
    init_mem[1] = 8'h01;
    run_prog("t2");
    chk("t2.s0_direct", 16'(dut.u_rf.regs[0]), 16'd21);
    chk("t2.s1_direct", 16'(dut.u_rf.regs[1]), 16'd13);
    chk("t2.s2_direct", 16'(dut.u_rf.regs[2]), 16'd8);
    chk("t2.s3_direct", 16'(dut.u_rf.regs[3]), 16'd5);
    chk("t2.no_we", 16'(st_q.size() - st_base), 16'd0);

    // Test 3: store address wraps from FF+1 to 00.
    p = '{8'h43, 8'h64, 8'h85, 8'hC3};
    load_prog(p);
    init_mem[8'hFF] = 8'hFF;
    init_mem[0] = 8'h5A;
    run_prog("t3");
    chk("t3.we_cycles", 16'(st_q.size() - st_base), 16'd1);
    if (st_q.size() > st_base)
      chk("t3.store", st_q[st_base], 16'h005A);

    // Test 4: jump past the ROM faults at the next fetch.
    p = '{8'h00, 8'hDE};
    load_prog(p);
    run_prog("t4");
    chk("t4.pc_direct", 16'(bus.address), 16'd32);
    chk("t4.fault_direct", 16'(bus.fault), 16'h1);

    // Test 5: clear during the MEM cycle of an LW.
    p = '{8'h49, 8'h27, 8'hC3};
    load_prog(p);
    init_mem[1] = 8'h01;
    model_run();
    do_reset("t5");
    @(posedge clk);
    @(posedge clk);
    #2;
    clear = 1'b1;
    #1;
    chk("t5.s2_cut", 16'(dut.u_rf.regs[2]), 16'h00);
    chk("t5.pc_cut", 16'(bus.address), 16'h00);
    chk("t5.halted_cut", 16'(bus.halted), 16'h0);
    @(posedge clk);
    #1;
    chk("t5.s2_held", 16'(dut.u_rf.regs[2]), 16'h00);
    @(negedge clk);
    st_base = st_q.size();
    wb_base = wb_q.size();
    clear = 1'b0;
    wait_halt(n);
    compare_model("t5", n);

    // Random forward-only programs.
    for (int t = 0; t < 12; t++) begin
      p.delete();
      for (int i = 0; i < 20; i++) begin
        ins = 8'($urandom);
        if (ins[7:6] == 2'b11) ins[5:0] = 6'($urandom_range(0, 6));
        p.push_back(ins);
      end
      load_prog(p);
      run_prog($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
